bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Requester-side agent for the 3-way round-robin tiny-AXI bus arbiter; one instance per bus master (e.g. I-cache, D-cache, DMA).
- Accepts a local read or write burst command, raises req, and waits for the arbiter's gnt pulse.
- Then drives the address and data phases on the shared bus while its sel is active, and returns a one-cycle finish pulse so the arbiter can re-arbitrate.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LEN_W, 4, burst length field width; beats = cmd_len + 1 (1..16).
- TIMEOUT_CYC, 255, slave-response watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  local command valid.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_we  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  beats-1.
- wd_valid  in  1  local write-data valid.
- wd_ready  out  1  local write data consumed.
- wd_data  in  DATA_W  local write data.
- rsp_valid  out  1  read beat valid.
- rsp_rdata  out  DATA_W  read beat data.
- rsp_done  out  1  one-cycle pulse, command complete.
- rsp_err  out  1  valid with rsp_done; 1=aborted by timeout.
- req  out  1  request to arbiter.
- gnt  in  1  grant pulse from arbiter (combinational on req).
- finish  out  1  one-cycle end-of-transaction pulse to arbiter.
- bus_avalid  out  1  address phase valid.
- bus_aready  in  1  slave address ready.
- bus_we  out  1  direction.
- bus_addr  out  ADDR_W  address.
- bus_len  out  LEN_W  burst length.
- bus_wvalid  out  1  write beat valid.
- bus_wready  in  1  slave write ready.
- bus_wdata  out  DATA_W  write data.
- bus_wlast  out  1  last write beat.
- bus_rvalid  in  1  read beat valid.
- bus_rdata  in  DATA_W  read data.
- bus_rlast  in  1  last read beat (informational).

Behaviour:
- Reset: state IDLE; req, finish, bus_avalid, bus_wvalid, rsp_valid, rsp_done, rsp_err all 0; bus_addr/bus_len/bus_we/beat counter cleared. Reset mid-burst abandons the transfer immediately with no finish pulse; the arbiter resets with it.
- States: IDLE, REQ, ADDR, WDAT, RDAT, FIN.
- IDLE: cmd_ready=1. On accept, latch we/addr/len into registers and go to REQ.
- REQ: req=1. gnt=1 -> ADDR next cycle; req drops in that cycle. gnt may arrive in the first REQ cycle.
- ADDR: bus_avalid=1 with the latched bus_we/bus_addr/bus_len (sel is valid from this cycle). Hold until bus_aready; then go to WDAT if we, else RDAT. Beat counter = 0.
- WDAT: pass-through: bus_wvalid=wd_valid, bus_wdata=wd_data, wd_ready=bus_wready. A beat completes on bus_wvalid&bus_wready. bus_wlast=(count==len). The beat with wlast -> FIN.
- RDAT: each bus_rvalid cycle -> rsp_valid=1, rsp_rdata=bus_rdata (combinational). The beat with count==len -> FIN. Extra rvalid beyond len is ignored.
- FIN: finish=1, rsp_done=1 for exactly one cycle; all bus valids 0; then IDLE. Throughput limit: next cmd accepted in IDLE, so min 1 idle cycle between bursts.
- gnt seen outside REQ: ignored; no state change.
- Latency, 1-beat write with immediately-ready slave: accept T0, req T1 (gnt T1), avalid T2, wvalid T3, finish T4.
- Beat counter is LEN_W wide; len=all-ones gives 16 beats with no wrap issue.
- All outputs except wd_ready, bus_wvalid, bus_wdata, rsp_valid and rsp_rdata are registered or decoded from state only.

Optional Feature:
- BUS_MASTER_TIMEOUT_EN defined: an 8+-bit watchdog counts consecutive cycles in ADDR/WDAT/RDAT with no handshake (aready, wready&wvalid, rvalid); the counter resets on any handshake.
- On reaching TIMEOUT_CYC: go to FIN, pulse finish and rsp_done with rsp_err=1.
- Undefined: no watchdog; a stalled slave holds the bus forever; rsp_err tied 0.

Test Plan:
- Single write, len=0, addr=0x1000, data=0xDEADBEEF, gnt same cycle as req, aready/wready tied 1 -> bus_avalid cycle 2, bus_wvalid+wlast cycle 3, finish+rsp_done cycle 4, rsp_err=0.
- Read burst len=3, slave returns 0x10,0x11,0x12,0x13 with one-cycle gaps -> 4 rsp_valid beats in order, rsp_done one cycle after the 4th beat.
- gnt delayed 5 cycles (other master busy) -> req held high 5 cycles, no bus_avalid before gnt, req low the cycle after gnt.
- Write len=15 with wd_valid toggling every other cycle -> exactly 16 bus beats, wlast only on the 16th, finish pulse width 1.
- Reset asserted during WDAT beat 2 of 4 -> all outputs 0 asynchronously, no finish; new command after reset completes normally.
- With BUS_MASTER_TIMEOUT_EN, TIMEOUT_CYC=8, aready held 0 -> finish, rsp_done and rsp_err=1 after 8 stalled ADDR cycles; without the macro -> stays in ADDR.

Source files
------------

// File: rtl/bus_master_port.sv
// bus_master_port: requester-side tiny-AXI bus agent (arbiter req/gnt, address phase, write/read bursts, finish)
// Ports: cmd_* local command in, wd_* local write data in, rsp_* read beats and completion out,
// req/gnt/finish arbiter handshake, bus_* shared bus address, write and read channels.
// Optional: define BUS_MASTER_TIMEOUT_EN for a slave watchdog that aborts after TIMEOUT_CYC stalled cycles with rsp_err.
module bus_master_port #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_done,
  output logic              rsp_err,
  output logic              req,
  input  logic              gnt,
  output logic              finish,
  output logic              bus_avalid,
  input  logic              bus_aready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LEN_W-1:0]  bus_len,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wlast,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rlast
);
  typedef enum logic [2:0] {IDLE, REQ, ADDR, WDAT, RDAT, FIN} state_t;
  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic              err_q, timeout;
  logic              unused_ok;
`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            active, hs;
  always_comb begin
    active  = state_q inside {ADDR, WDAT, RDAT};
    hs      = (state_q == ADDR && bus_aready) || (bus_wvalid && bus_wready) || (state_q == RDAT && bus_rvalid);
    timeout = active && !hs && wdog_q == WD_W'(TIMEOUT_CYC - 1);
    wdog_d  = active && !hs ? wdog_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
`else
  assign timeout = 1'b0;
`endif
  assign unused_ok  = bus_rlast | (TIMEOUT_CYC == 0);
  assign cmd_ready  = state_q == IDLE;
  assign req        = state_q == REQ;
  assign bus_avalid = state_q == ADDR;
  assign finish     = state_q == FIN;
  assign rsp_done   = state_q == FIN;
  assign rsp_err    = err_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_len    = len_q;
  assign bus_wvalid = state_q == WDAT && wd_valid;
  assign bus_wdata  = wd_data;
  assign wd_ready   = state_q == WDAT && bus_wready;
  assign bus_wlast  = state_q == WDAT && cnt_q == len_q;
  assign rsp_valid  = state_q == RDAT && bus_rvalid;
  assign rsp_rdata  = bus_rdata;
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = REQ;
        we_d    = cmd_we;
        addr_d  = cmd_addr;
        len_d   = cmd_len;
      end
      REQ:  state_d = gnt ? ADDR : REQ;
      ADDR: if (bus_aready) begin
        state_d = we_q ? WDAT : RDAT;
        cnt_d   = '0;
      end
      WDAT: if (bus_wvalid && bus_wready) begin
        state_d = bus_wlast ? FIN : WDAT;
        cnt_d   = cnt_q + 1'b1;
      end
      RDAT: if (bus_rvalid) begin
        state_d = cnt_q == len_q ? FIN : RDAT;
        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = FIN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= timeout;
    end
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: randomized scoreboard bench with bus slave, arbiter and local data source models
module tb_bus_master_port;
  localparam int AW = 32, DW = 32, LW = 4, TO = 8;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [LW-1:0] len;} cmd_t;
  typedef struct packed {logic err; logic [4:0] beats;} done_t;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_we = 0, wd_valid = 0, gnt = 0;
  logic bus_aready = 0, bus_wready = 0, bus_rvalid = 0, bus_rlast = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wd_data = '0, bus_rdata = '0;
  logic cmd_ready, wd_ready, rsp_valid, rsp_done, rsp_err, req, finish;
  logic bus_avalid, bus_we, bus_wvalid, bus_wlast;
  logic [AW-1:0] bus_addr;
  logic [LW-1:0] bus_len;
  logic [DW-1:0] rsp_rdata, bus_wdata;

  bus_master_port #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_done(rsp_done), .rsp_err(rsp_err),
    .req(req), .gnt(gnt), .finish(finish), .bus_avalid(bus_avalid), .bus_aready(bus_aready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_len(bus_len), .bus_wvalid(bus_wvalid),
    .bus_wready(bus_wready), .bus_wdata(bus_wdata), .bus_wlast(bus_wlast), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_rlast(bus_rlast)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int t_acc = 0, t_av = 0, t_w = 0, t_fin = 0, req_len = 0, last_beats = 0, cur_beats = 0, lastb = -10;
  int p_a = 100, p_w = 100, p_r = 100, p_wd = 100, gnt_cyc = 1;
  bit spur = 0, r_dir = 0, wd_alt = 0;
  cmd_t exp_a[$];
  logic [DW:0] exp_w[$];
  logic [DW-1:0] exp_r[$], src[$];
  done_t exp_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input logic err, input bit with_addr, input logic [DW-1:0] d0);
    cmd_t c;
    done_t dn;
    int n;
    bit acc;
    c.we = we; c.addr = a; c.len = l;
    if (with_addr) exp_a.push_back(c);
    dn.err = err;
    dn.beats = 5'(l) + 5'd1;
    exp_d.push_back(dn);
    if (we) for (int i = 0; i <= int'(l); i++) begin
      logic [DW-1:0] d;
      d = (i == 0) ? d0 : DW'($urandom);
      src.push_back(d);
      exp_w.push_back({i == int'(l), d});
    end
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_len = l;
    n = 0; acc = 0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      if (acc) t_acc = cyc;
      step();
      n++;
    end
    chk("cmd_accepted", 64'(acc), 64'd1);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_d.size() > 0 && n < 3000) begin
      step();
      n++;
    end
    chk("drain_in_time", 64'(exp_d.size()), 64'd0);
  endtask

  initial begin : slave
    int rem, ridx, sa, sw, sr, rq;
    bit rtog, wtog, extra;
    rem = 0; ridx = 0; sa = 0; sw = 0; sr = 0; rq = 0; rtog = 0; wtog = 0; extra = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_avalid && bus_aready && !bus_we) begin
          rem = int'(bus_len) + 1;
          ridx = 0;
        end
        if (wd_valid && wd_ready && src.size() > 0) void'(src.pop_front());
        rq = req ? rq + 1 : 0;
      end
      step();
      if (!rst_n) begin
        rem = 0; rq = 0; sa = 0; sw = 0; sr = 0; rtog = 0; extra = 0;
        {gnt, bus_aready, bus_wready, bus_rvalid, bus_rlast, wd_valid} = '0;
        continue;
      end
      gnt = req ? (rq + 1 >= gnt_cyc) : (spur && $urandom_range(0, 3) == 0);
      bus_aready = p_a > 0 && (sa >= 3 || $urandom_range(1, 100) <= p_a);
      sa = bus_aready ? 0 : sa + 1;
      bus_wready = sw >= 3 || $urandom_range(1, 100) <= p_w;
      wtog = !wtog;
      wd_valid = src.size() > 0 && (wd_alt ? wtog : (sw >= 3 || $urandom_range(1, 100) <= p_wd));
      sw = (wd_valid && bus_wready) ? 0 : sw + 1;
      if (wd_valid) wd_data = src[0];
      else wd_data = DW'($urandom);
      if (rem > 0 && (r_dir ? rtog : (sr >= 3 || $urandom_range(1, 100) <= p_r))) begin
        bus_rvalid = 1;
        bus_rdata = r_dir ? DW'(32'h10 + ridx) : DW'($urandom);
        exp_r.push_back(bus_rdata);
        rem--; ridx++; sr = 0;
        bus_rlast = rem == 0;
        extra = rem == 0 && $urandom_range(0, 1) == 1;
      end else if (extra) begin
        bus_rvalid = 1; bus_rlast = 0; bus_rdata = DW'($urandom); extra = 0;
      end else begin
        bus_rvalid = 0; bus_rlast = 0;
        sr = rem > 0 ? sr + 1 : 0;
      end
      rtog = rem > 0 ? !rtog : 1'b0;
    end
  end

  initial begin : monitor
    int reqc;
    bit avp, gp, fp;
    done_t e;
    reqc = 0; avp = 0; gp = 0; fp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reqc = 0; avp = 0; gp = 0; fp = 0; cur_beats = 0;
        continue;
      end
      if (req || bus_avalid) chk("req_avalid_excl", 64'(req && bus_avalid), 64'd0);
      if (bus_avalid && !avp) begin
        chk("avalid_after_gnt", 64'(gp), 64'd1);
        t_av = cyc;
        req_len = reqc;
      end
      if (bus_avalid && bus_aready) begin
        chk("addr_expected", 64'(exp_a.size() > 0), 64'd1);
        if (exp_a.size() > 0) chk("addr_phase", 64'({bus_we, bus_addr, bus_len}), 64'(exp_a.pop_front()));
      end
      if (wd_valid && wd_ready) chk("wd_consumed_on_bus", 64'(bus_wvalid && bus_wready), 64'd1);
      if (bus_wvalid && bus_wready) begin
        chk("wbeat_expected", 64'(exp_w.size() > 0), 64'd1);
        if (exp_w.size() > 0) chk("wbeat_last_data", 64'({bus_wlast, bus_wdata}), 64'(exp_w.pop_front()));
        lastb = cyc;
        cur_beats++;
        if (bus_wlast) t_w = cyc;
      end
      if (rsp_valid) begin
        chk("rbeat_expected", 64'(exp_r.size() > 0), 64'd1);
        if (exp_r.size() > 0) chk("rbeat_data", 64'(rsp_rdata), 64'(exp_r.pop_front()));
        lastb = cyc;
        cur_beats++;
      end
      if (finish || rsp_done) chk("finish_eq_done", 64'(finish), 64'(rsp_done));
      if (rsp_done) begin
        chk("finish_width", 64'(fp), 64'd0);
        chk("done_expected", 64'(exp_d.size() > 0), 64'd1);
        if (exp_d.size() > 0) begin
          e = exp_d.pop_front();
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          if (!e.err) begin
            chk("done_after_last_beat", 64'(cyc), 64'(lastb + 1));
            chk("beat_count", 64'(cur_beats), 64'(e.beats));
          end
        end
        t_fin = cyc;
        last_beats = cur_beats;
        cur_beats = 0;
      end
      avp = bus_avalid;
      gp = req && gnt;
      fp = finish;
      reqc = req ? reqc + 1 : 0;
    end
  end

  initial begin : main
    int n;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({req, finish, bus_avalid, bus_wvalid, rsp_valid, rsp_done, rsp_err, bus_wlast}), 64'd0);
    chk("rst_bus_regs", 64'({bus_we, bus_addr, bus_len}), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    rst_n = 1;

    issue(1'b1, 32'h1000, 4'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    wait_idle();
    chk("lat_avalid", 64'(t_av - t_acc), 64'd2);
    chk("lat_wlast", 64'(t_w - t_acc), 64'd3);
    chk("lat_finish", 64'(t_fin - t_acc), 64'd4);

    r_dir = 1;
    issue(1'b0, 32'h2000, 4'd3, 1'b0, 1'b1, '0);
    wait_idle();
    chk("read_beats", 64'(last_beats), 64'd4);
    r_dir = 0;

    gnt_cyc = 5;
    issue(1'b0, 32'h3000, 4'd0, 1'b0, 1'b1, '0);
    wait_idle();
    chk("req_cycles_before_gnt", 64'(req_len), 64'd5);
    gnt_cyc = 1;

    wd_alt = 1;
    issue(1'b1, 32'h4000, 4'd15, 1'b0, 1'b1, DW'($urandom));
    wait_idle();
    chk("long_write_beats", 64'(last_beats), 64'd16);
    wd_alt = 0;

    issue(1'b1, 32'h5000, 4'd3, 1'b0, 1'b1, DW'($urandom));
    n = 0;
    while (cur_beats < 1 && n < 100) begin
      step();
      n++;
    end
    chk("reached_beat2", 64'(cur_beats), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_ctrl", 64'({req, bus_avalid, bus_wvalid, bus_wlast, wd_ready, finish, rsp_done, rsp_err, rsp_valid}), 64'd0);
    chk("async_rst_regs", 64'({bus_we, bus_addr, bus_len}), 64'd0);
    exp_a.delete(); exp_w.delete(); exp_r.delete(); exp_d.delete(); src.delete();
    repeat (2) step();
    rst_n = 1;
    step();
    issue(1'b1, 32'h6000, 4'd3, 1'b0, 1'b1, DW'($urandom));
    wait_idle();
    chk("post_reset_beats", 64'(last_beats), 64'd4);

    p_a = 0;
`ifdef BUS_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h7000, 4'd2, 1'b1, 1'b0, '0);
    wait_idle();
    chk("timeout_cycles", 64'(t_fin - t_av), 64'd8);
    p_a = 100;
`else
    issue(1'b0, 32'h7000, 4'd2, 1'b0, 1'b1, '0);
    repeat (40) step();
    chk("stall_holds_addr", 64'(bus_avalid), 64'd1);
    chk("stall_no_done", 64'(exp_d.size()), 64'd1);
    p_a = 100;
    wait_idle();
`endif

    spur = 1;
    for (int k = 0; k < 150; k++) begin
      p_a = $urandom_range(30, 100);
      p_w = $urandom_range(30, 100);
      p_r = $urandom_range(30, 100);
      p_wd = $urandom_range(30, 100);
      gnt_cyc = $urandom_range(1, 4);
      issue(1'($urandom_range(0, 1)), AW'($urandom), LW'($urandom_range(0, 15)), 1'b0, 1'b1, DW'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();
    chk("scoreboard_empty", 64'(exp_a.size() + exp_w.size() + exp_r.size() + src.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
